// File: rtl/sbmips_stack.sv
`default_nettype none
// ============================================================================
// Module      : sbmips_stack
// Description : LIFO stack of DEPTH x WIDTH registers with push, pop,
//               top-of-stack peek and same-cycle replace. dout is a
//               registered capture of the top entry. Sticky overflow and
//               underflow flags.
//               Build option: define STACK_GUARD_EN to enable boundary
//               protection. Without it the stack pointer wraps, count
//               saturates and the error flags are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module sbmips_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   tos,
    input  logic [WIDTH-1:0]       din,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   err_ovf,
    output logic                   err_udf
);

    // DEPTH must be a power of two (>= 2) so the pointer wraps naturally.
    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_CW       = c_AW + 1;
    localparam logic [c_AW-1:0] c_SP_ONE   = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_sp;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_dout;

    logic             w_empty;
    logic             w_full;
    logic [c_AW-1:0]  w_top;
    logic [WIDTH-1:0] w_top_data;
    logic [c_AW-1:0]  w_sp_nxt;
    logic [c_CW-1:0]  w_count_nxt;
    logic             w_dout_ld;
    logic             w_mem_we;
    logic [c_AW-1:0]  w_waddr;
`ifdef STACK_GUARD_EN
    logic             w_ovf_evt;
    logic             w_udf_evt;
`endif

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_CNT_FULL);
    assign w_top      = r_sp - c_SP_ONE;
    // Read uses pre-edge contents; no forwarding of this cycle's write.
    assign w_top_data = r_mem[w_top];

    // Decode the prioritised operation into next-state controls.
    always_comb begin
        w_sp_nxt    = r_sp;
        w_count_nxt = r_count;
        w_dout_ld   = 1'b0;
        w_mem_we    = 1'b0;
        w_waddr     = r_sp;
`ifdef STACK_GUARD_EN
        w_ovf_evt   = 1'b0;
        w_udf_evt   = 1'b0;
`endif
        if (push && pop) begin
            if (w_empty) begin
                // Replace on an empty stack degenerates to a plain push.
                w_mem_we    = 1'b1;
                w_sp_nxt    = r_sp + c_SP_ONE;
                w_count_nxt = r_count + c_CNT_ONE;
            end else begin
                // Replace: old top goes out, din takes its slot.
                w_dout_ld = 1'b1;
                w_mem_we  = 1'b1;
                w_waddr   = w_top;
            end
        end else if (pop) begin
`ifdef STACK_GUARD_EN
            if (w_empty) begin
                w_udf_evt = 1'b1;
            end else begin
                w_dout_ld   = 1'b1;
                w_sp_nxt    = w_top;
                w_count_nxt = r_count - c_CNT_ONE;
            end
`else
            // Unguarded: pointer wraps, count floors at zero.
            w_dout_ld = 1'b1;
            w_sp_nxt  = w_top;
            if (!w_empty) begin
                w_count_nxt = r_count - c_CNT_ONE;
            end
`endif
        end else begin
            // Peek captures the old top before any push in the same cycle.
            if (tos && !w_empty) begin
                w_dout_ld = 1'b1;
            end
`ifdef STACK_GUARD_EN
            if (tos && w_empty) begin
                w_udf_evt = 1'b1;
            end
`endif
            if (push) begin
`ifdef STACK_GUARD_EN
                if (w_full) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_mem_we    = 1'b1;
                    w_sp_nxt    = r_sp + c_SP_ONE;
                    w_count_nxt = r_count + c_CNT_ONE;
                end
`else
                // Unguarded: overwrite slot sp when full, count saturates.
                w_mem_we = 1'b1;
                w_sp_nxt = r_sp + c_SP_ONE;
                if (!w_full) begin
                    w_count_nxt = r_count + c_CNT_ONE;
                end
`endif
            end
        end
    end

    // Storage array, not reset. A write landing while reset is held can only
    // hit slot 0, which reset has just declared free.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_waddr] <= din;
        end
    end

    // Pointer, occupancy and captured-data registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp    <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            r_sp    <= w_sp_nxt;
            r_count <= w_count_nxt;
            if (w_dout_ld) begin
                r_dout <= w_top_data;
            end
        end
    end

`ifdef STACK_GUARD_EN
    logic r_err_ovf;
    logic r_err_udf;

    // Sticky error flags; a new event outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_err_ovf <= w_ovf_evt | (r_err_ovf & ~err_clr);
            r_err_udf <= w_udf_evt | (r_err_udf & ~err_clr);
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`else
    // Without boundary protection there are no error conditions.
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

    assign dout  = r_dout;
    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_sbmips_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbmips_stack
// Description : Self-checking bench for sbmips_stack: directed vector table,
//               hand-written boundary sequences and randomized traffic
//               checked against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbmips_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             tos;
    logic             err_clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err_ovf;
    logic             err_udf;

    sbmips_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .tos     (tos),
        .din     (din),
        .err_clr (err_clr),
        .dout    (dout),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .err_ovf (err_ovf),
        .err_udf (err_udf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: circular slot array plus occupancy.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_mk  [DEPTH];
    int               m_sp;
    int               m_cnt;
    logic [WIDTH-1:0] m_dout;
    bit               m_dk;
    bit               m_ovf;
    bit               m_udf;

    typedef struct {
        bit         pu;
        bit         po;
        bit         to;
        logic [7:0] d;
        logic [7:0] exp_dout;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sp   = 0;
        m_cnt  = 0;
        m_dout = '0;
        m_dk   = 1'b1;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_push(input logic [7:0] d);
        m_mem[m_sp] = d;
        m_mk[m_sp]  = 1'b1;
        m_sp        = (m_sp + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
    endtask

    task automatic model_step(input bit pu, input bit po, input bit to,
                              input logic [7:0] d, input bit ec);
        int top;
        bit ov;
        bit ud;
        top = (m_sp + DEPTH - 1) % DEPTH;
        ov  = 1'b0;
        ud  = 1'b0;
        if (pu && po) begin
            if (m_cnt == 0) begin
                model_push(d);
            end else begin
                m_dout     = m_mem[top];
                m_dk       = m_mk[top];
                m_mem[top] = d;
                m_mk[top]  = 1'b1;
            end
        end else if (po) begin
            if (m_cnt == 0 && GUARD) begin
                ud = 1'b1;
            end else begin
                m_dout = m_mem[top];
                m_dk   = m_mk[top];
                m_sp   = top;
                if (m_cnt > 0) m_cnt--;
            end
        end else begin
            if (to) begin
                if (m_cnt == 0) begin
                    if (GUARD) ud = 1'b1;
                end else begin
                    m_dout = m_mem[top];
                    m_dk   = m_mk[top];
                end
            end
            if (pu) begin
                if (m_cnt == DEPTH && GUARD) ov = 1'b1;
                else model_push(d);
            end
        end
        if (GUARD) begin
            m_ovf = ov || (m_ovf && !ec);
            m_udf = ud || (m_udf && !ec);
        end
    endtask

    task automatic apply(input bit pu, input bit po, input bit to,
                         input logic [7:0] d, input bit ec);
        push    = pu;
        pop     = po;
        tos     = to;
        din     = d;
        err_clr = ec;
        model_step(pu, po, to, d, ec);
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        tos     = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_count"}, count, m_cnt);
        chk({tag, "_empty"}, empty, m_cnt == 0);
        chk({tag, "_full"}, full, m_cnt == DEPTH);
        chk({tag, "_err_ovf"}, err_ovf, m_ovf);
        chk({tag, "_err_udf"}, err_udf, m_udf);
        if (m_dk) chk({tag, "_dout"}, dout, m_dout);
    endtask

    initial begin
        logic [7:0] d;
        rst     = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        tos     = 1'b0;
        din     = '0;
        err_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mk[i] = 1'b0;
        model_reset();

        // Directed vectors: {push, pop, tos, din, expected dout, expected count}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 2};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 3};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 2};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h22, 2};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h5A, 8'h22, 2};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, 2};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h66, 8'h5A, 3};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h66, 2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h99, 8'h11, 1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 0};

        // Reset state, asynchronously visible before any clock edge
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_err_ovf", err_ovf, 1'b0);
        chk("rst_err_udf", err_udf, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_hold_count", count, 0);
        chk("rst_hold_empty", empty, 1'b1);
        rst = 1'b0;

        // Directed table: push/pop/tos/replace/tos+push
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].pu, vecs[i].po, vecs[i].to, vecs[i].d, 1'b0);
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_empty", i), empty, vecs[i].exp_cnt == 0);
            chk($sformatf("vec%0d_err_udf", i), err_udf, 1'b0);
        end

        // Fill to full, then push once more at the boundary
        for (int i = 0; i < DEPTH; i++) apply(1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
        chk("fill_full", full, 1'b1);
        chk("fill_count", count, 16);
        apply(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        chk("ovf_count", count, 16);
`ifdef STACK_GUARD_EN
        chk("ovf_flag", err_ovf, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("ovf_pop_dout", dout, 8'h0F);
`else
        chk("ovf_flag", err_ovf, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("ovf_pop_dout", dout, 8'hFF);
`endif
        chk("ovf_pop_count", count, 15);
        for (int i = 0; i < 15; i++) begin
            apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            check_model("drain");
        end
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_model("clr_ovf");

        // Underflow behaviour on an empty stack
        apply(1'b1, 1'b0, 1'b0, 8'hAB, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("pre_udf_dout", dout, 8'hAB);
        apply(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("tos_empty_dout", dout, 8'hAB);
        check_model("tos_empty");
        apply(1'b0, 0, 0, 8'h00, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef STACK_GUARD_EN
        chk("udf_flag", err_udf, 1'b1);
        chk("udf_dout", dout, 8'hAB);
        chk("udf_count", count, 0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_clr", err_udf, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("udf_clr_vs_evt", err_udf, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_clr2", err_udf, 1'b0);
`else
        chk("udf_flag", err_udf, 1'b0);
        chk("udf_count", count, 0);
        check_model("udf_wrap");
`endif

        // Asynchronous reset between edges discards an in-flight push
        apply(1'b1, 1'b0, 1'b0, 8'h12, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'h34, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("pre_arst_dout", dout, 8'h34);
        push = 1'b1;
        din  = 8'h77;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_dout", dout, 8'h00);
        chk("arst_empty", empty, 1'b1);
        push = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check_model("post_arst");
        apply(1'b1, 1'b0, 1'b0, 8'h44, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("post_arst_pop_dout", dout, 8'h44);
        chk("post_arst_pop_count", count, 0);

        // Alternating push/pop with random data
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            apply(1'b1, 1'b0, 1'b0, d, 1'b0);
            chk("alt_push_count", count, 1);
            apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("alt_pop_dout", dout, d);
            chk("alt_pop_count", count, 0);
        end

        // Randomized traffic against the reference model
        for (int k = 0; k < 800; k++) begin
            bit pu, po, to, ec;
            int pu_pct;
            pu_pct = (((k / 100) % 2) == 0) ? 75 : 25;
            pu = ($urandom_range(0, 99) < pu_pct);
            po = ($urandom_range(0, 99) < (100 - pu_pct) / 2);
            to = ($urandom_range(0, 99) < 20);
            ec = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
                model_reset();
                check_model("rnd_arst");
            end
            apply(pu, po, to, 8'($urandom), ec);
            check_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
